// File: rtl/codes.sv
// Shared encodings for the control path: sequencer state as seen by the decoder.
// Combinational constants only. No latency.
// No flow control.
package codes;

    typedef logic [1:0] state_t;

    localparam state_t FETCH = 2'd0;
    localparam state_t EXEC1 = 2'd1;
    localparam state_t EXEC2 = 2'd2;
    localparam state_t HALT  = 2'd3;

endpackage

// File: rtl/cpu_state_sequencer.sv
// Multicycle instruction sequencer: FETCH -> EXEC1 -> EXEC2 -> FETCH/HALT, plus watchdog.
// Latency: 3 cycles per instruction with no waits; state_o is registered, advance_o is combinational.
// Backpressure: mem_waitrequest_i (when an access is active) and stall_i hold the current state.
//
// Ports:
//   clk_i, rst_ni         clock (rising edge), asynchronous active-low reset
//   mem_waitrequest_i     memory bus has not accepted the current access
//   mem_access_i          decoder requests a RAM read/write in the current state
//   stall_i               mult/div unit busy
//   pc_next_i             next PC; zero at the end of EXEC2 means halt
//   state_o               current state (codes::state_t)
//   advance_o             state changes at the next edge; qualifies datapath writes
//   active_o              state_o != HALT
//   fault_o               sticky watchdog fault
//   instr_count_o         retired instructions (perf counters only)
//   cycle_count_o         active cycles (perf counters only)
//
// Optional feature: define SEQUENCER_PERF_COUNTERS_EN to build the two 32-bit
// counters; otherwise both count ports are tied to zero.
// TIMEOUT_W must satisfy 2**TIMEOUT_W > WAIT_TIMEOUT.

module cpu_state_sequencer
    import codes::*;
#(
    parameter int WAIT_TIMEOUT = 1023,
    parameter int TIMEOUT_W    = 10
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_waitrequest_i,
    input  logic        mem_access_i,
    input  logic        stall_i,
    input  logic [31:0] pc_next_i,
    output state_t      state_o,
    output logic        advance_o,
    output logic        active_o,
    output logic        fault_o,
    output logic [31:0] instr_count_o,
    output logic [31:0] cycle_count_o
);

    localparam logic [TIMEOUT_W-1:0] C_TIMEOUT = TIMEOUT_W'(WAIT_TIMEOUT);

    state_t                 r_state;
    logic [TIMEOUT_W-1:0]   r_hold_cnt;
    logic                   r_fault;

    logic                   w_hold;
    logic                   w_timeout;
    logic                   w_advance;
    state_t                 w_next;

    // Hold conditions per state. EXEC1/EXEC2 only care about the bus when
    // they actually issued an access.
    always_comb begin
        w_hold = 1'b0;
        case (r_state)
            FETCH:   w_hold = mem_waitrequest_i;
            EXEC1:   w_hold = mem_access_i & mem_waitrequest_i;
            EXEC2:   w_hold = (mem_access_i & mem_waitrequest_i) | stall_i;
            default: w_hold = 1'b0;
        endcase
    end

    // Watchdog fires on the cycle the counter has already reached the limit
    // and the state would be held yet again.
    assign w_timeout = w_hold && (r_hold_cnt >= C_TIMEOUT);

    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = HALT;
        end else if (!w_hold) begin
            case (r_state)
                FETCH:   w_next = EXEC1;
                EXEC1:   w_next = EXEC2;
                EXEC2:   w_next = (pc_next_i == 32'h0) ? HALT : FETCH;
                default: w_next = HALT;
            endcase
        end
    end

    // Gated by reset so that an aborted instruction never emits a write strobe.
    assign w_advance = rst_ni & (w_next != r_state);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= FETCH;
            r_hold_cnt <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_advance) begin
                r_hold_cnt <= '0;
            end else if (w_hold && (r_hold_cnt != '1)) begin
                r_hold_cnt <= r_hold_cnt + TIMEOUT_W'(1);
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign state_o   = r_state;
    assign advance_o = w_advance;
    assign active_o  = (r_state != HALT);
    assign fault_o   = r_fault;

`ifdef SEQUENCER_PERF_COUNTERS_EN
    logic [31:0] r_instr_count;
    logic [31:0] r_cycle_count;
    logic        w_retire;

    // A watchdog exit from EXEC2 is an abort, not a retirement.
    assign w_retire = w_advance && (r_state == EXEC2) && !w_timeout;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_instr_count <= '0;
            r_cycle_count <= '0;
        end else begin
            if (w_retire) begin
                r_instr_count <= r_instr_count + 32'd1;
            end
            if (r_state != HALT) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
        end
    end

    assign instr_count_o = r_instr_count;
    assign cycle_count_o = r_cycle_count;
`else
    assign instr_count_o = 32'd0;
    assign cycle_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_state_sequencer.sv
module tb_cpu_state_sequencer;
    import codes::*;

`ifdef SEQUENCER_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic        w;
        logic        a;
        logic        s;
        logic [31:0] pc;
        state_t      st;
        logic        adv;
        logic        flt;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_waitrequest_i;
    logic        mem_access_i;
    logic        stall_i;
    logic [31:0] pc_next_i;
    state_t      state_o;
    logic        advance_o;
    logic        active_o;
    logic        fault_o;
    logic [31:0] instr_count_o;
    logic [31:0] cycle_count_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    cpu_state_sequencer #(.WAIT_TIMEOUT(8), .TIMEOUT_W(4)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .mem_waitrequest_i (mem_waitrequest_i),
        .mem_access_i      (mem_access_i),
        .stall_i           (stall_i),
        .pc_next_i         (pc_next_i),
        .state_o           (state_o),
        .advance_o         (advance_o),
        .active_o          (active_o),
        .fault_o           (fault_o),
        .instr_count_o     (instr_count_o),
        .cycle_count_o     (cycle_count_o)
    );

    function automatic vec_t mk(logic w, logic a, logic s, logic [31:0] pc,
                                state_t st, logic adv, logic flt);
        vec_t v;
        v = '{w: w, a: a, s: s, pc: pc, st: st, adv: adv, flt: flt};
        return v;
    endfunction

    // Reset pulse spanning one rising edge; released mid low phase.
    task automatic apply_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        mem_waitrequest_i = 1'b0;
        mem_access_i = 1'b0;
        stall_i = 1'b0;
        pc_next_i = 32'h4;
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
    endtask

    task automatic drive(input vec_t v);
        mem_waitrequest_i = v.w;
        mem_access_i = v.a;
        stall_i = v.s;
        pc_next_i = v.pc;
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        rst_ni = 1'b1;
        mem_waitrequest_i = 1'b0;
        mem_access_i = 1'b0;
        stall_i = 1'b0;
        pc_next_i = 32'h4;
        #1 rst_ni = 1'b0;
        #2;
        obs = {state_o, advance_o, fault_o, active_o};
        tests_run++;
        if (obs !== {FETCH, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset {state,adv,fault,active}: got %b want %b", obs, {FETCH, 3'b001});
        end
        tests_run++;
        if ({instr_count_o, cycle_count_o} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset counts: got %0d/%0d want 0/0", instr_count_o, cycle_count_o);
        end
        // Reset must hold across clock edges.
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        obs = {state_o, advance_o, fault_o, active_o};
        tests_run++;
        if (obs !== {FETCH, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_held {state,adv,fault,active}: got %b want %b", obs, {FETCH, 3'b001});
        end
    endtask

    task automatic test_no_wait();
        vec_t v[$];
        logic [4:0] obs, exp;
        apply_reset();
        v.push_back(mk(0, 0, 0, 32'h4, FETCH, 1, 0));
        v.push_back(mk(0, 0, 0, 32'h4, EXEC1, 1, 0));
        v.push_back(mk(0, 0, 0, 32'h4, EXEC2, 1, 0));
        v.push_back(mk(0, 0, 0, 32'h4, FETCH, 1, 0));
        v.push_back(mk(0, 0, 0, 32'h4, EXEC1, 1, 0));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            obs = {state_o, advance_o, fault_o, active_o};
            exp = {v[i].st, v[i].adv, v[i].flt, v[i].st != HALT};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL no_wait[%0d] {state,adv,fault,active}: got %b want %b", i, obs, exp);
            end
            @(negedge clk_i);
        end
        #1;
        tests_run++;
        if ({instr_count_o, cycle_count_o} !== {(PERF ? 32'd1 : 32'd0), (PERF ? 32'd5 : 32'd0)}) begin
            tests_failed++;
            $display("FAIL no_wait counts: got %0d/%0d want %0d/%0d", instr_count_o, cycle_count_o,
                     PERF ? 1 : 0, PERF ? 5 : 0);
        end
    endtask

    task automatic test_fetch_wait();
        vec_t v[$];
        logic [4:0] obs, exp;
        apply_reset();
        for (int k = 0; k < 3; k++) v.push_back(mk(1, 0, 0, 32'h4, FETCH, 0, 0));
        v.push_back(mk(0, 0, 0, 32'h4, FETCH, 1, 0));
        v.push_back(mk(0, 0, 0, 32'h4, EXEC1, 1, 0));
        v.push_back(mk(0, 0, 0, 32'h4, EXEC2, 1, 0));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            obs = {state_o, advance_o, fault_o, active_o};
            exp = {v[i].st, v[i].adv, v[i].flt, v[i].st != HALT};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL fetch_wait[%0d] {state,adv,fault,active}: got %b want %b", i, obs, exp);
            end
            @(negedge clk_i);
        end
        #1;
        tests_run++;
        if ({instr_count_o, cycle_count_o} !== {(PERF ? 32'd1 : 32'd0), (PERF ? 32'd6 : 32'd0)}) begin
            tests_failed++;
            $display("FAIL fetch_wait counts: got %0d/%0d want %0d/%0d", instr_count_o, cycle_count_o,
                     PERF ? 1 : 0, PERF ? 6 : 0);
        end
    endtask

    task automatic test_exec1_wait();
        vec_t v[$];
        logic [4:0] obs, exp;
        apply_reset();
        v.push_back(mk(0, 0, 0, 32'h4, FETCH, 1, 0));
        v.push_back(mk(1, 1, 0, 32'h4, EXEC1, 0, 0));
        v.push_back(mk(1, 1, 0, 32'h4, EXEC1, 0, 0));
        v.push_back(mk(0, 1, 0, 32'h4, EXEC1, 1, 0));
        v.push_back(mk(0, 0, 0, 32'h4, EXEC2, 1, 0));
        v.push_back(mk(0, 0, 0, 32'h4, FETCH, 1, 0));
        // Waitrequest without an access must not hold EXEC1 or EXEC2.
        v.push_back(mk(1, 0, 0, 32'h4, EXEC1, 1, 0));
        v.push_back(mk(1, 0, 0, 32'h4, EXEC2, 1, 0));
        v.push_back(mk(0, 0, 0, 32'h4, FETCH, 1, 0));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            obs = {state_o, advance_o, fault_o, active_o};
            exp = {v[i].st, v[i].adv, v[i].flt, v[i].st != HALT};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL exec1_wait[%0d] {state,adv,fault,active}: got %b want %b", i, obs, exp);
            end
            @(negedge clk_i);
        end
        #1;
        tests_run++;
        if ({instr_count_o, cycle_count_o} !== {(PERF ? 32'd2 : 32'd0), (PERF ? 32'd9 : 32'd0)}) begin
            tests_failed++;
            $display("FAIL exec1_wait counts: got %0d/%0d want %0d/%0d", instr_count_o, cycle_count_o,
                     PERF ? 2 : 0, PERF ? 9 : 0);
        end
    endtask

    task automatic test_exec2_halt();
        vec_t v[$];
        logic [4:0] obs, exp;
        logic [2:0] r;
        apply_reset();
        v.push_back(mk(0, 0, 0, 32'h4, FETCH, 1, 0));
        v.push_back(mk(0, 0, 0, 32'h4, EXEC1, 1, 0));
        for (int k = 0; k < 5; k++) v.push_back(mk(0, 0, 1, 32'h0, EXEC2, 0, 0));
        v.push_back(mk(0, 0, 0, 32'h0, EXEC2, 1, 0));
        // HALT ignores every input combination.
        for (int k = 0; k < 21; k++) begin
            r = 3'(k);
            v.push_back(mk(r[0], r[2], r[1], 32'h4, HALT, 0, 0));
        end
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            obs = {state_o, advance_o, fault_o, active_o};
            exp = {v[i].st, v[i].adv, v[i].flt, v[i].st != HALT};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL exec2_halt[%0d] {state,adv,fault,active}: got %b want %b", i, obs, exp);
            end
            @(negedge clk_i);
        end
        #1;
        tests_run++;
        if ({instr_count_o, cycle_count_o} !== {(PERF ? 32'd1 : 32'd0), (PERF ? 32'd8 : 32'd0)}) begin
            tests_failed++;
            $display("FAIL exec2_halt frozen counts: got %0d/%0d want %0d/%0d", instr_count_o, cycle_count_o,
                     PERF ? 1 : 0, PERF ? 8 : 0);
        end
    endtask

    task automatic test_watchdog();
        vec_t v[$];
        logic [4:0] obs, exp;
        apply_reset();
        for (int k = 0; k < 8; k++) v.push_back(mk(1, 0, 0, 32'h4, FETCH, 0, 0));
        v.push_back(mk(1, 0, 0, 32'h4, FETCH, 1, 0));
        for (int k = 0; k < 3; k++) v.push_back(mk(1, 0, 0, 32'h4, HALT, 0, 1));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            obs = {state_o, advance_o, fault_o, active_o};
            exp = {v[i].st, v[i].adv, v[i].flt, v[i].st != HALT};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL watchdog[%0d] {state,adv,fault,active}: got %b want %b", i, obs, exp);
            end
            @(negedge clk_i);
        end
        #1;
        tests_run++;
        if ({instr_count_o, cycle_count_o} !== {32'd0, (PERF ? 32'd9 : 32'd0)}) begin
            tests_failed++;
            $display("FAIL watchdog counts: got %0d/%0d want 0/%0d", instr_count_o, cycle_count_o,
                     PERF ? 9 : 0);
        end
    endtask

    // Long holds in every state back to back; the hold counter must restart
    // on each transition or the cumulative hold trips the watchdog.
    task automatic test_back_to_back();
        vec_t v[$];
        logic [4:0] obs, exp;
        apply_reset();
        for (int k = 0; k < 5; k++) v.push_back(mk(1, 0, 0, 32'h4, FETCH, 0, 0));
        v.push_back(mk(0, 0, 0, 32'h4, FETCH, 1, 0));
        for (int k = 0; k < 5; k++) v.push_back(mk(1, 1, 0, 32'h4, EXEC1, 0, 0));
        v.push_back(mk(0, 1, 0, 32'h4, EXEC1, 1, 0));
        v.push_back(mk(1, 1, 1, 32'h0, EXEC2, 0, 0));
        v.push_back(mk(1, 1, 0, 32'h0, EXEC2, 0, 0));
        v.push_back(mk(0, 0, 1, 32'h0, EXEC2, 0, 0));
        v.push_back(mk(1, 1, 0, 32'h0, EXEC2, 0, 0));
        v.push_back(mk(1, 0, 1, 32'h0, EXEC2, 0, 0));
        v.push_back(mk(0, 0, 0, 32'h4, EXEC2, 1, 0));
        v.push_back(mk(0, 0, 0, 32'h8, FETCH, 1, 0));
        v.push_back(mk(0, 0, 0, 32'h8, EXEC1, 1, 0));
        v.push_back(mk(0, 0, 0, 32'h8, EXEC2, 1, 0));
        v.push_back(mk(0, 0, 0, 32'h8, FETCH, 1, 0));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            obs = {state_o, advance_o, fault_o, active_o};
            exp = {v[i].st, v[i].adv, v[i].flt, v[i].st != HALT};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d] {state,adv,fault,active}: got %b want %b", i, obs, exp);
            end
            @(negedge clk_i);
        end
        #1;
        tests_run++;
        if ({instr_count_o, cycle_count_o} !== {(PERF ? 32'd2 : 32'd0), (PERF ? 32'd22 : 32'd0)}) begin
            tests_failed++;
            $display("FAIL back_to_back counts: got %0d/%0d want %0d/%0d", instr_count_o, cycle_count_o,
                     PERF ? 2 : 0, PERF ? 22 : 0);
        end
    endtask

    task automatic test_async_reset();
        vec_t v[$];
        vec_t w[$];
        logic [4:0] obs, exp;
        apply_reset();
        v.push_back(mk(0, 0, 0, 32'h4, FETCH, 1, 0));
        v.push_back(mk(1, 1, 0, 32'h4, EXEC1, 0, 0));
        v.push_back(mk(1, 1, 0, 32'h4, EXEC1, 0, 0));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            obs = {state_o, advance_o, fault_o, active_o};
            exp = {v[i].st, v[i].adv, v[i].flt, v[i].st != HALT};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL async_pre[%0d] {state,adv,fault,active}: got %b want %b", i, obs, exp);
            end
            @(negedge clk_i);
        end
        // Still stalled in EXEC1; drop reset between edges.
        #2 rst_ni = 1'b0;
        #1;
        obs = {state_o, advance_o, fault_o, active_o};
        tests_run++;
        if (obs !== {FETCH, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL async_reset {state,adv,fault,active}: got %b want %b", obs, {FETCH, 3'b001});
        end
        tests_run++;
        if ({instr_count_o, cycle_count_o} !== 64'd0) begin
            tests_failed++;
            $display("FAIL async_reset counts: got %0d/%0d want 0/0", instr_count_o, cycle_count_o);
        end
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        w.push_back(mk(0, 0, 0, 32'h4, FETCH, 1, 0));
        w.push_back(mk(0, 0, 0, 32'h4, EXEC1, 1, 0));
        w.push_back(mk(0, 0, 0, 32'h4, EXEC2, 1, 0));
        w.push_back(mk(0, 0, 0, 32'h4, FETCH, 1, 0));
        foreach (w[i]) begin
            drive(w[i]);
            #1;
            obs = {state_o, advance_o, fault_o, active_o};
            exp = {w[i].st, w[i].adv, w[i].flt, w[i].st != HALT};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL async_post[%0d] {state,adv,fault,active}: got %b want %b", i, obs, exp);
            end
            @(negedge clk_i);
        end
    endtask

    initial begin
        test_reset();
        test_no_wait();
        test_fetch_wait();
        test_exec1_wait();
        test_exec2_halt();
        test_watchdog();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cpu_state_sequencer.md
Name: cpu_state_sequencer

Overview:
Multicycle instruction sequencer that drives the control decoder's `state_i`. It steps through FETCH -> EXEC1 -> EXEC2 and then back to FETCH, or into HALT. The sequence holds while the memory bus asserts waitrequest or a multicycle unit (mult/div) is busy. It also emits `advance_o`, the single-cycle qualifier that datapath write enables (PC, IR, regfile, RAM write) are gated with, so that a held state never repeats a write.

Parameters:
- `WAIT_TIMEOUT`, 1023: max consecutive cycles held in one non-HALT state before a fault is raised.
- `TIMEOUT_W`, 10: width of the hold counter; must satisfy 2^`TIMEOUT_W` > `WAIT_TIMEOUT`.

Ports:
- `clk_i`  in  1  clock, rising edge
- `rst_ni`  in  1  asynchronous active-low reset
- `mem_waitrequest_i`  in  1  memory bus busy; current access not yet accepted
- `mem_access_i`  in  1  decoder is requesting a RAM read or write in the current state (OR of `ram_read_en`, `ram_write_en`)
- `stall_i`  in  1  multicycle execute unit busy (mult/div)
- `pc_next_i`  in  32  PC value to be written at the end of EXEC2
- `state_o`  out  2  current state, type `state_t` from `codes`: FETCH, EXEC1, EXEC2, HALT
- `advance_o`  out  1  state leaves its current value at the next edge
- `active_o`  out  1  CPU running (`state_o` != HALT)
- `fault_o`  out  1  sticky; set when a watchdog timeout forced HALT
- `instr_count_o`  out  32  retired instruction count (optional feature)
- `cycle_count_o`  out  32  active cycle count (optional feature)

Behaviour:
- Reset is asynchronous and active-low: `rst_ni`=0 immediately forces `state_o`=FETCH, hold counter=0, `fault_o`=0, both counts=0. Consequently `active_o`=1 and `advance_o`=0 while in reset.
- Reset asserted mid-instruction aborts it: no `advance_o` pulse; FETCH restarts after release.
- FETCH: instruction read is always issued.
  - `mem_waitrequest_i`=0 -> EXEC1.
  - Otherwise hold.
- EXEC1:
  - `mem_access_i`=1 and `mem_waitrequest_i`=1 -> hold.
  - Otherwise -> EXEC2.
  - `mem_waitrequest_i` is ignored when `mem_access_i`=0.
- EXEC2:
  - Hold if (`mem_access_i` and `mem_waitrequest_i`) or `stall_i`.
  - Otherwise, `pc_next_i`==32'h0 -> HALT; any other value -> FETCH.
  - Waitrequest and stall occurring in the same cycle: hold until both clear.
- HALT: terminal state. Leaves only on reset; `advance_o`=0.
- `advance_o` is combinational from the current state and current inputs. It is 1 exactly in the cycles where the registered state will change at the next edge.
- `state_o` is registered; there is no combinational path from inputs to `state_o`.
- Hold counter:
  - Resets to 0 on every transition.
  - Increments each cycle the state is held in FETCH/EXEC1/EXEC2.
  - Saturates; it does not wrap.
- Watchdog: when the hold counter reaches `WAIT_TIMEOUT` while still held, the next state is HALT and `fault_o` is set to 1 at that same edge.
  - `advance_o` is 1 for that cycle.
  - A watchdog transition is not a retirement.
- Latency with no waits: exactly 3 cycles per instruction. An instruction fetched at cycle N has its EXEC2 `advance_o` at cycle N+2.

Optional Feature:
- Macro: `SEQUENCER_PERF_COUNTERS_EN`.
- Defined:
  - `instr_count_o` increments by 1 on each EXEC2 `advance_o`, including the one into HALT.
  - `cycle_count_o` increments every cycle with `state_o` != HALT.
  - Both wrap modulo 2^32.
  - Both are frozen in HALT and cleared by reset.
- Not defined: both ports are driven constant 0 and no counter flops are synthesised.

Test Plan:
- Reset release, `mem_waitrequest_i`=0, `mem_access_i`=0, `stall_i`=0, `pc_next_i`=32'h4 -> `state_o` FETCH, EXEC1, EXEC2, FETCH on consecutive cycles; `advance_o`=1 every cycle; `instr_count_o`=1 after the first EXEC2.
- `mem_waitrequest_i`=1 for 3 cycles in FETCH -> FETCH held 4 cycles total, `advance_o`=0 for the first 3; EXEC1 entered on the 4th edge; no duplicate `advance_o`.
- EXEC1 with `mem_access_i`=1 (load) and waitrequest for 2 cycles -> EXEC1 held 3 cycles. Same waitrequest with `mem_access_i`=0 -> EXEC1 held 1 cycle only.
- EXEC2 with `stall_i`=1 for 5 cycles, then `pc_next_i`=32'h0 -> EXEC2 held 6 cycles, then HALT; `active_o`=0; remains in HALT 20 further cycles; counters frozen.
- `WAIT_TIMEOUT`=8, `mem_waitrequest_i` stuck 1 in FETCH -> HALT entered after 9 cycles in FETCH; `fault_o`=1; `instr_count_o` unchanged.
- Assert `rst_ni`=0 asynchronously mid-EXEC1 stall -> `state_o`=FETCH without waiting for a clock edge; `fault_o`=0; counters=0; normal sequencing resumes after release.
